// File: rtl/conv2_pkg.sv
// Shared constants and types for the conv2 kernel ROM fetch path.
package conv2_pkg;

   localparam int K_TAPS      = 25;
   localparam int NUM_FILTERS = 10;
   localparam int AW          = 8;
   localparam int DW          = 16;
   localparam int FIFO_W      = 2 * DW + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int npairs(input int k);
      return (k + 1) / 2;
   endfunction

   localparam int NPAIRS = npairs(K_TAPS);

endpackage

// File: rtl/conv2_skid_fifo2.sv
// Two-entry synchronous FIFO used to absorb registered ROM data while the consumer stalls.
module conv2_skid_fifo2
   import conv2_pkg::*;
#(
   parameter int W = FIFO_W
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count,
   output logic         empty
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_push = push && (count != 2'd2);
   assign do_pop  = pop && (count != 2'd0);
   assign dout    = mem[rd_ptr];
   assign empty   = (count == 2'd0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= !wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= !rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/conv2_kernel_fetch_ctrl.sv
// Fetches one conv2 filter from the dual-port kernel ROM, two taps per cycle, and streams the pairs.
// Optional stall counter output enabled by defining CONV2_KFETCH_STALL_CNT_EN.
module conv2_kernel_fetch_ctrl
   import conv2_pkg::*;
(
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic [3:0]    filter_idx,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rom_addr_a,
   output logic [AW-1:0] rom_addr_b,
   input  logic [DW-1:0] rom_q_a,
   input  logic [DW-1:0] rom_q_b,
   output logic          w_valid,
   input  logic          w_ready,
   output logic [DW-1:0] w_a,
   output logic [DW-1:0] w_b,
   output logic          w_b_valid,
   output logic          w_last
`ifdef CONV2_KFETCH_STALL_CNT_EN
   ,
   output logic [15:0]   stall_cycles
`endif
);

   localparam logic [3:0]    MAX_IDX    = 4'(NUM_FILTERS);
   localparam logic [AW-1:0] LAST_PAIR  = AW'(NPAIRS - 1);
   localparam logic [AW-1:0] PRE_LAST   = AW'(NPAIRS - 2);
   localparam logic [AW-1:0] FIRST_BOFS = AW'((K_TAPS == 1) ? 0 : 1);
   localparam bit            ODD_TAPS   = (K_TAPS % 2) == 1;

   // Handshake: a pair transfers on a cycle where w_valid && w_ready; once raised,
   // w_valid and the pair stay put until that transfer happens.
   state_t          state;
   state_t          state_next;
   logic            done_next;
   logic            issue;
   logic            start_ok;
   logic            issue_last;
   logic            credit_ok;
   logic [AW-1:0]   base;
   logic [AW-1:0]   pair_cnt;
   logic            q_valid;
   logic            q_last;
   logic            q_bvalid;
   logic [FIFO_W-1:0] q_word;
   logic [FIFO_W-1:0] fifo_dout;
   logic [FIFO_W-1:0] out_word;
   logic [1:0]      fifo_count;
   logic            fifo_empty;
   logic            fifo_push;
   logic            fifo_pop;

   assign start_ok   = start && (state == IDLE) && (filter_idx < MAX_IDX);
   assign base       = AW'(int'(filter_idx) * K_TAPS);
   assign issue_last = (pair_cnt == LAST_PAIR);
   // q_valid is the single pair in flight through the ROM register.
   assign credit_ok  = (fifo_count + {1'b0, q_valid}) < 2'd2;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      issue      = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) state_next = FETCH;
         end
         FETCH: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (issue_last) state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (w_valid && w_ready && w_last) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Addresses hold the next pair to issue and never step past the final pair.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pair_cnt   <= '0;
         rom_addr_a <= '0;
         rom_addr_b <= '0;
         q_valid    <= 1'b0;
         q_last     <= 1'b0;
         q_bvalid   <= 1'b0;
      end else begin
         q_valid <= issue;
         if (issue) begin
            q_last   <= issue_last;
            q_bvalid <= !(issue_last && ODD_TAPS);
         end
         if (start_ok) begin
            pair_cnt   <= '0;
            rom_addr_a <= base;
            rom_addr_b <= base + FIRST_BOFS;
         end else if (issue && !issue_last) begin
            pair_cnt   <= pair_cnt + AW'(1);
            rom_addr_a <= rom_addr_a + AW'(2);
            rom_addr_b <= (ODD_TAPS && (pair_cnt == PRE_LAST)) ? rom_addr_a + AW'(2)
                                                                : rom_addr_a + AW'(3);
         end
      end
   end

   assign q_word    = {q_last, q_bvalid, rom_q_a, q_bvalid ? rom_q_b : {DW{1'b0}}};
   // Fresh ROM data bypasses the FIFO when it is empty and the consumer is ready.
   assign fifo_push = q_valid && !(fifo_empty && w_ready);
   assign fifo_pop  = w_ready && !fifo_empty;

   conv2_skid_fifo2 #(.W(FIFO_W)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .din     (q_word),
      .dout    (fifo_dout),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   assign out_word  = fifo_empty ? q_word : fifo_dout;
   assign w_valid   = q_valid || !fifo_empty;
   assign w_last    = w_valid && out_word[2*DW+1];
   assign w_b_valid = w_valid && out_word[2*DW];
   assign w_a       = out_word[2*DW-1:DW];
   assign w_b       = out_word[DW-1:0];
   assign busy      = (state != IDLE);

`ifdef CONV2_KFETCH_STALL_CNT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= 16'd0;
      end else if (start_ok) begin
         stall_cycles <= 16'd0;
      end else if (busy && w_valid && !w_ready && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv2_kernel_fetch_ctrl.sv
// Bench for conv2_kernel_fetch_ctrl: ROM model rom[i]=i, scoreboard queue, negedge monitor.
module tb_conv2_kernel_fetch_ctrl;
   import conv2_pkg::*;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    filter_idx = 4'd0;
   logic          busy;
   logic          done;
   logic [AW-1:0] rom_addr_a;
   logic [AW-1:0] rom_addr_b;
   logic [DW-1:0] rom_q_a;
   logic [DW-1:0] rom_q_b;
   logic          w_valid;
   logic          w_ready = 1'b0;
   logic [DW-1:0] w_a;
   logic [DW-1:0] w_b;
   logic          w_b_valid;
   logic          w_last;
`ifdef CONV2_KFETCH_STALL_CNT_EN
   logic [15:0]   stall_cycles;
`endif

   int vectors = 0;
   int fails = 0;
   int cyc = 0;
   int ready_mode = 0;
   logic [FIFO_W-1:0] exp_q[$];
   logic [DW-1:0] rom [256];

   conv2_kernel_fetch_ctrl dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .filter_idx (filter_idx),
      .busy       (busy),
      .done       (done),
      .rom_addr_a (rom_addr_a),
      .rom_addr_b (rom_addr_b),
      .rom_q_a    (rom_q_a),
      .rom_q_b    (rom_q_b),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_a        (w_a),
      .w_b        (w_b),
      .w_b_valid  (w_b_valid),
      .w_last     (w_last)
`ifdef CONV2_KFETCH_STALL_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   initial for (int i = 0; i < 256; i++) rom[i] = DW'(i);
   always @(posedge clock) begin
      rom_q_a <= rom[rom_addr_a];
      rom_q_b <= rom[rom_addr_b];
   end

   always @(posedge clock) begin
      #1;
      case (ready_mode)
         0:       w_ready = 1'b1;
         1:       w_ready = ($urandom_range(0, 9) < 3);
         default: w_ready = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted pair is matched against the head of the expected queue.
   always @(negedge clock) begin
      if (reset_n && w_valid && w_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            fails++;
            $display("FAIL unexpected_pair: got a=%0d b=%0d, required no output", w_a, w_b);
         end else begin
            check("pair {last,bvalid,a,b}", {30'd0, w_last, w_b_valid, w_a, w_b}, {30'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic push_filter(input int f);
      for (int p = 0; p < NPAIRS; p++) begin
         int   a;
         logic bv;
         logic lst;
         a   = f * K_TAPS + 2 * p;
         bv  = (2 * p + 1 < K_TAPS);
         lst = (p == NPAIRS - 1);
         exp_q.push_back({lst, bv, DW'(a), bv ? DW'(a + 1) : DW'(0)});
      end
   endtask

   task automatic pulse_start(input logic [3:0] idx, output int t0);
      @(posedge clock); #1;
      start = 1'b1;
      filter_idx = idx;
      t0 = cyc;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic run_filter(input logic [3:0] idx, output int first_lat, output int done_lat,
                             output int first_ab, output int last_a, output int max_addr,
                             output logic occ_ok);
      int t0;
      push_filter(int'(idx));
      pulse_start(idx, t0);
      first_lat = -1; done_lat = -1; first_ab = -1; last_a = -1; max_addr = 0; occ_ok = 1'b1;
      for (int k = 0; k < 400 && done_lat < 0; k++) begin
         @(negedge clock);
         if (w_valid && first_lat < 0) begin
            first_lat = cyc - t0;
            first_ab  = {int'(w_a), 16'd0} | int'(w_b);
         end
         if (w_valid && w_last) last_a = int'(w_a);
         if (busy && int'(rom_addr_a) > max_addr) max_addr = int'(rom_addr_a);
         if (busy && int'(rom_addr_b) > max_addr) max_addr = int'(rom_addr_b);
         if (dut.u_fifo.count > 2'd2) occ_ok = 1'b0;
         if (done) done_lat = cyc - t0;
      end
      if (done_lat < 0) check("done_timeout", 64'(done_lat), 64'(0));
   endtask

   initial begin
      int   fl, dl, fab, la, mx, t0, busy_hits, done_hits;
      logic ok;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      check("rst_w_valid", 64'(w_valid), 0);
      check("rst_w_last", 64'(w_last), 0);
      check("rst_w_b_valid", 64'(w_b_valid), 0);
      check("rst_addrs", {48'd0, rom_addr_a, rom_addr_b}, 0);
      reset_n = 1'b1;
      ready_mode = 0;
      repeat (2) @(negedge clock);

      // 1: filter 0, ready high
      run_filter(4'd0, fl, dl, fab, la, mx, ok);
      check("t1_first_latency", 64'(fl), 64'(2));
      check("t1_done_latency", 64'(dl), 64'(15));
      check("t1_first_pair", 64'(fab), 64'(32'h0000_0001));
      check("t1_last_a", 64'(la), 64'(24));
      check("t1_queue_empty", 64'(exp_q.size()), 0);
      repeat (3) @(negedge clock);

      // 2: filter 9, ready high, address range
      run_filter(4'd9, fl, dl, fab, la, mx, ok);
      check("t2_first_pair", 64'(fab), 64'((225 << 16) | 226));
      check("t2_last_a", 64'(la), 64'(249));
      check("t2_max_addr", 64'(mx), 64'(249));
      check("t2_done_latency", 64'(dl), 64'(15));
      check("t2_queue_empty", 64'(exp_q.size()), 0);
      repeat (3) @(negedge clock);

      // 3: filter 3, random 30% ready
      ready_mode = 1;
      run_filter(4'd3, fl, dl, fab, la, mx, ok);
      check("t3_first_pair", 64'(fab), 64'((75 << 16) | 76));
      check("t3_last_a", 64'(la), 64'(99));
      check("t3_fifo_occupancy_ok", 64'(ok), 64'(1));
      check("t3_queue_empty", 64'(exp_q.size()), 0);
      ready_mode = 0;
      repeat (3) @(negedge clock);

      // 4: stall for 20 valid cycles, then release
      ready_mode = 2;
      @(negedge clock);
      push_filter(0);
      pulse_start(4'd0, t0);
      fl = -1;
      for (int k = 0; k < 10 && fl < 0; k++) begin
         @(negedge clock);
         if (w_valid) fl = cyc - t0;
      end
      check("t4_first_latency", 64'(fl), 64'(2));
      ok = 1'b1;
      for (int k = 0; k < 19; k++) begin
         @(negedge clock);
         if (!(w_valid && w_a == 16'd0 && w_b == 16'd1 && w_b_valid)) ok = 1'b0;
      end
      check("t4_pair0_held", 64'(ok), 64'(1));
      ready_mode = 0;
      dl = -1;
      for (int k = 0; k < 100 && dl < 0; k++) begin
         @(negedge clock);
         if (done) dl = cyc - t0;
      end
      check("t4_done_seen", 64'(dl >= 0), 64'(1));
      check("t4_queue_empty", 64'(exp_q.size()), 0);
`ifdef CONV2_KFETCH_STALL_CNT_EN
      check("t4_stall_cycles", 64'(stall_cycles), 64'(20));
`endif
      repeat (3) @(negedge clock);

      // 5a: start while busy is ignored
      push_filter(0);
      pulse_start(4'd0, t0);
      repeat (3) @(posedge clock);
      #1; start = 1'b1; filter_idx = 4'd5;
      @(posedge clock); #1; start = 1'b0;
      @(negedge clock);
      check("t5_busy_held", 64'(busy), 64'(1));
      dl = -1;
      for (int k = 0; k < 60 && dl < 0; k++) begin
         @(negedge clock);
         if (done) dl = cyc - t0;
      end
      check("t5_done_latency", 64'(dl), 64'(15));
      check("t5_queue_empty", 64'(exp_q.size()), 0);

      // 5b: out-of-range filter index in IDLE is ignored
      repeat (3) @(negedge clock);
      pulse_start(4'd12, t0);
      busy_hits = 0; done_hits = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (busy) busy_hits++;
         if (done) done_hits++;
      end
      check("t5_idx12_busy", 64'(busy_hits), 0);
      check("t5_idx12_done", 64'(done_hits), 0);

      // 6: reset at pair 5, then restart with filter 1
      push_filter(0);
      pulse_start(4'd0, t0);
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clock);
         if (w_valid && w_a == 16'd10) ok = 1'b1;
      end
      check("t6_reached_pair5", 64'(ok), 64'(1));
      #1; reset_n = 1'b0;
      #1;
      check("t6_rst_busy", 64'(busy), 0);
      check("t6_rst_w_valid", 64'(w_valid), 0);
      check("t6_rst_flags", {62'd0, w_last, w_b_valid}, 0);
      check("t6_rst_addrs", {48'd0, rom_addr_a, rom_addr_b}, 0);
      exp_q.delete();
      done_hits = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         if (done) done_hits++;
      end
      reset_n = 1'b1;
      @(negedge clock);
      if (done) done_hits++;
      check("t6_no_done_pulse", 64'(done_hits), 0);
      run_filter(4'd1, fl, dl, fab, la, mx, ok);
      check("t6_restart_first_pair", 64'(fab), 64'((25 << 16) | 26));
      check("t6_restart_last_a", 64'(la), 64'(49));
      check("t6_restart_done_latency", 64'(dl), 64'(15));
      check("t6_queue_empty", 64'(exp_q.size()), 0);

      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
